// File: rtl/count_seq_checker_if.sv
// count_seq_checker_if: sampled count stream from the sequencer plus the checker's lap/error status
// Signals: cnt_in/cnt_valid (sequencer -> checker), locked/lap_done/seq_err/lap_count/err_count (checker -> consumers)
// Modports: master = sequencer/consumer side, slave = checker side
interface count_seq_checker_if #(
  parameter int W     = 3,
  parameter int LAP_W = 8,
  parameter int ERR_W = 4
);
  logic [W-1:0]     cnt_in;
  logic             cnt_valid;
  logic             locked;
  logic             lap_done;
  logic             seq_err;
  logic [LAP_W-1:0] lap_count;
  logic [ERR_W-1:0] err_count;
  modport master (output cnt_in, cnt_valid, input locked, lap_done, seq_err, lap_count, err_count);
  modport slave  (input cnt_in, cnt_valid, output locked, lap_done, seq_err, lap_count, err_count);
endinterface

// File: rtl/count_seq_checker.sv
// count_seq_checker: locks onto the 1..MAX_VAL count sequence, counts laps, flags and tallies deviations
// Ports: clk (rising edge), rst (async active-high), seq_i (slave modport: cnt_in/cnt_valid in,
//   locked/lap_done/seq_err/lap_count/err_count out, all registered)
// Option: define CNT_CHK_RESYNC_EN to let a valid 1 re-lock from ERROR; otherwise ERROR is terminal until rst
module count_seq_checker #(
  parameter int W       = 3,
  parameter int MAX_VAL = 5,
  parameter int LAP_W   = 8,
  parameter int ERR_W   = 4
) (
  input logic clk,
  input logic rst,
  count_seq_checker_if.slave seq_i
);
  typedef enum logic [1:0] {IDLE, TRACK, ERROR} state_t;
  state_t           state_q, state_d;
  logic [W-1:0]     exp_q, exp_d;
  logic [LAP_W-1:0] lap_q, lap_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             locked_q, locked_d, lap_done_q, lap_done_d, seq_err_q, seq_err_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q    <= IDLE;
      exp_q      <= W'(2);
      lap_q      <= '0;
      err_q      <= '0;
      locked_q   <= 1'b0;
      lap_done_q <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      lap_q      <= lap_d;
      err_q      <= err_d;
      locked_q   <= locked_d;
      lap_done_q <= lap_done_d;
      seq_err_q  <= seq_err_d;
    end
  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    lap_d      = lap_q;
    err_d      = err_q;
    locked_d   = locked_q;
    lap_done_d = 1'b0;
    seq_err_d  = 1'b0;
    if (seq_i.cnt_valid)
      case (state_q)
        IDLE:
          if (seq_i.cnt_in == W'(1)) begin
            state_d  = TRACK;
            exp_d    = W'(2);
            locked_d = 1'b1;
          end
        TRACK:
          if (seq_i.cnt_in == exp_q) begin
            exp_d      = (exp_q == W'(MAX_VAL)) ? W'(1) : exp_q + W'(1);
            lap_done_d = exp_q == W'(MAX_VAL);
            lap_d      = lap_done_d ? lap_q + LAP_W'(1) : lap_q;
          end else begin
            state_d   = ERROR;
            seq_err_d = 1'b1;
            locked_d  = 1'b0;
            err_d     = &err_q ? err_q : err_q + ERR_W'(1);
          end
        default: begin
`ifdef CNT_CHK_RESYNC_EN
          if (seq_i.cnt_in == W'(1)) begin
            state_d  = TRACK;
            exp_d    = W'(2);
            locked_d = 1'b1;
          end
`else
          state_d = ERROR;
`endif
        end
      endcase
  end
  assign seq_i.locked    = locked_q;
  assign seq_i.lap_done  = lap_done_q;
  assign seq_i.seq_err   = seq_err_q;
  assign seq_i.lap_count = lap_q;
  assign seq_i.err_count = err_q;
endmodule
